// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA RAM arbiter.
package ram_arbiter_pkg;

    localparam int unsigned AW_UNBANKED = 16;
    localparam int unsigned AW_BANKED   = 20;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam logic ST_OPEN   = 1'b0;
    localparam logic ST_FORCED = 1'b1;

endpackage

// File: rtl/ram_arbiter.sv
// Arbitrates the single-port SoC RAM between the 65xx CPU and one DMA requester,
// stalling the CPU via RDY and bounding the stall with a forced CPU-priority window.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned AW            = AW_UNBANKED,
    parameter int unsigned MAX_CPU_STALL = 4,
    parameter int unsigned CPU_WINDOW    = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_cpu_ab,
    input  logic [7:0]    i_cpu_do,
    input  logic          i_cpu_we_n,
    input  logic          i_cpu_ram_sel,
    output logic          o_cpu_rdy,
    input  logic          i_dma_req,
    input  logic          i_dma_we,
    input  logic [AW-1:0] i_dma_addr,
    input  logic [7:0]    i_dma_wdata,
    output logic          o_dma_gnt,
    output logic          o_dma_rvalid,
    output logic [7:0]    o_dma_rdata,
    output logic [AW-1:0] o_ram_addr,
    output logic [7:0]    o_ram_wdata,
    output logic          o_ram_we,
    input  logic [7:0]    i_ram_rdata
);

    localparam int unsigned SW = (MAX_CPU_STALL > 0) ? $clog2(MAX_CPU_STALL + 1) : 1;
    localparam int unsigned WW = (CPU_WINDOW > 1) ? $clog2(CPU_WINDOW) : 1;
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_CPU_STALL);
    localparam logic [WW-1:0] WIN_LAST  = WW'(CPU_WINDOW - 1);

    logic          r_state;
    logic          w_state_next;
    logic [SW-1:0] r_stall_cnt;
    logic [SW-1:0] w_stall_next;
    logic [WW-1:0] r_win_cnt;
    logic [WW-1:0] w_win_next;
    logic          r_rvalid;

    owner_e        w_owner;
    logic          w_cpu_rdy;
    logic          w_dma_gnt;
    logic          w_cpu_wr;
    logic          w_conflict;

    assign w_cpu_wr   = i_cpu_ram_sel & ~i_cpu_we_n;
    assign w_conflict = i_dma_req & i_cpu_ram_sel;

    always_comb begin
        w_owner      = OWN_CPU;
        w_cpu_rdy    = 1'b1;
        w_dma_gnt    = 1'b0;
        w_state_next = r_state;
        w_stall_next = r_stall_cnt;
        w_win_next   = r_win_cnt;
        if (i_reset) begin
            w_state_next = ST_OPEN;
            w_stall_next = '0;
            w_win_next   = '0;
        end else if (r_state == ST_OPEN) begin
            // Stall limit takes precedence so FORCED is entered even when a write wins.
            if (w_conflict && (r_stall_cnt == STALL_MAX)) begin
                w_state_next = ST_FORCED;
                w_win_next   = '0;
            end else if (w_cpu_wr) begin
                w_owner = OWN_CPU;
            end else if (i_dma_req && !i_cpu_ram_sel) begin
                w_owner   = OWN_DMA;
                w_dma_gnt = 1'b1;
            end else if (i_dma_req) begin
                w_owner   = OWN_DMA;
                w_dma_gnt = 1'b1;
                w_cpu_rdy = 1'b0;
            end
            w_stall_next = w_cpu_rdy ? '0 : r_stall_cnt + 1'b1;
        end else begin
            if (!i_cpu_ram_sel && i_dma_req) begin
                w_owner   = OWN_DMA;
                w_dma_gnt = 1'b1;
            end
            w_stall_next = '0;
            if (r_win_cnt == WIN_LAST) begin
                w_state_next = ST_OPEN;
                w_win_next   = '0;
            end else begin
                w_win_next = r_win_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_OPEN;
            r_stall_cnt <= '0;
            r_win_cnt   <= '0;
            r_rvalid    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_stall_cnt <= w_stall_next;
            r_win_cnt   <= w_win_next;
            r_rvalid    <= w_dma_gnt & ~i_dma_we;
        end
    end

    assign o_cpu_rdy    = w_cpu_rdy;
    assign o_dma_gnt    = w_dma_gnt;
    // A read scheduled before reset is discarded rather than presented during reset.
    assign o_dma_rvalid = r_rvalid & ~i_reset;
    assign o_dma_rdata  = i_ram_rdata;

    assign o_ram_addr  = (w_owner == OWN_DMA) ? i_dma_addr  : i_cpu_ab;
    assign o_ram_wdata = (w_owner == OWN_DMA) ? i_dma_wdata : i_cpu_do;
    assign o_ram_we    = ~i_reset & ((w_owner == OWN_DMA) ? i_dma_we : w_cpu_wr);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, DMA read scoreboard, scenario tasks.
module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we_n;
    logic        cpu_ram_sel;
    logic        cpu_rdy;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [7:0]  dma_rdata;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] shadow [0:65535];
    logic [7:0] mem    [0:65535];
    logic       mem_init_done = 1'b0;

    ram_arbiter #(.AW(16), .MAX_CPU_STALL(4), .CPU_WINDOW(2)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cpu_ab      (cpu_ab),
        .i_cpu_do      (cpu_do),
        .i_cpu_we_n    (cpu_we_n),
        .i_cpu_ram_sel (cpu_ram_sel),
        .o_cpu_rdy     (cpu_rdy),
        .i_dma_req     (dma_req),
        .i_dma_we      (dma_we),
        .i_dma_addr    (dma_addr),
        .i_dma_wdata   (dma_wdata),
        .o_dma_gnt     (dma_gnt),
        .o_dma_rvalid  (dma_rvalid),
        .o_dma_rdata   (dma_rdata),
        .o_ram_addr    (ram_addr),
        .o_ram_wdata   (ram_wdata),
        .o_ram_we      (ram_we),
        .i_ram_rdata   (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Behavioural single-port RAM with 1-cycle read latency
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
            mem_init_done <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Scoreboard: pop one expected byte per dma_rvalid
    always begin
        @(negedge clk);
        #2;
        if (dma_rvalid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_rvalid: got rvalid=1 data=%h expected no rvalid", dma_rdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dma_rdata !== e) begin
                    n_err++;
                    $display("FAIL sb_rdata: got %h expected %h", dma_rdata, e);
                end
            end
        end
    end

    task automatic drive(input logic rst, input logic sel, input logic we_n,
                         input logic [15:0] ab, input logic [7:0] dout, input logic req,
                         input logic dwe, input logic [15:0] da, input logic [7:0] dwd);
        @(negedge clk);
        reset = rst; cpu_ram_sel = sel; cpu_we_n = we_n; cpu_ab = ab; cpu_do = dout;
        dma_req = req; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 16'h1234, 8'h99, 1, 1, 16'h0222, 8'h11);
            n_cmp++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b expected 1", cpu_rdy); end
            n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b expected 0", dma_gnt); end
            n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b expected 0", ram_we); end
            n_cmp++; if (ram_addr !== 16'h1234) begin n_err++; $display("FAIL reset_addr: got %h expected 1234", ram_addr); end
            n_cmp++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b expected 0", dma_rvalid); end
        end
        drive(0, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    endtask

    task automatic test_no_conflict();
        drive(0, 0, 1, 16'h0000, 8'h00, 1, 0, 16'h0200, 8'h00);
        n_cmp++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL nc_gnt: got %b expected 1", dma_gnt); end
        n_cmp++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL nc_rdy: got %b expected 1", cpu_rdy); end
        n_cmp++; if (ram_addr !== 16'h0200) begin n_err++; $display("FAIL nc_addr: got %h expected 0200", ram_addr); end
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL nc_we: got %b expected 0", ram_we); end
        exp_q.push_back(shadow[16'h0200]);
        drive(0, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        n_cmp++; if (dma_rvalid !== 1'b1) begin n_err++; $display("FAIL nc_rvalid: got %b expected 1", dma_rvalid); end
        drive(0, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        n_cmp++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL nc_rvalid_clr: got %b expected 0", dma_rvalid); end
    endtask

    task automatic test_cpu_write();
        drive(0, 1, 0, 16'h0010, 8'h55, 1, 1, 16'h0011, 8'h77);
        n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL cw_we: got %b expected 1", ram_we); end
        n_cmp++; if (ram_addr !== 16'h0010) begin n_err++; $display("FAIL cw_addr: got %h expected 0010", ram_addr); end
        n_cmp++; if (ram_wdata !== 8'h55) begin n_err++; $display("FAIL cw_wdata: got %h expected 55", ram_wdata); end
        n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL cw_gnt: got %b expected 0", dma_gnt); end
        n_cmp++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL cw_rdy: got %b expected 1", cpu_rdy); end
        shadow[16'h0010] = 8'h55;
        drive(0, 0, 1, 16'h0000, 8'h00, 1, 1, 16'h0011, 8'h77);
        n_cmp++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL cw_dma_gnt: got %b expected 1", dma_gnt); end
        n_cmp++; if (ram_addr !== 16'h0011) begin n_err++; $display("FAIL cw_dma_addr: got %h expected 0011", ram_addr); end
        n_cmp++; if (ram_we !== 1'b1 || ram_wdata !== 8'h77) begin
            n_err++; $display("FAIL cw_dma_wr: got we=%b data=%h expected we=1 data=77", ram_we, ram_wdata);
        end
        shadow[16'h0011] = 8'h77;
        drive(0, 0, 1, 16'h0000, 8'h00, 1, 0, 16'h0010, 8'h00);
        exp_q.push_back(shadow[16'h0010]);
        drive(0, 0, 1, 16'h0000, 8'h00, 1, 0, 16'h0011, 8'h00);
        exp_q.push_back(shadow[16'h0011]);
        drive(0, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    endtask

    // Continuous conflict: 4 stalls, 1 limit cycle, 2 FORCED cycles, repeating every 7
    task automatic test_stall_limit(input logic [15:0] base, input int ncyc, input string tag);
        logic [15:0] da;
        logic        stall_exp;
        da = base;
        for (int k = 0; k < ncyc; k++) begin
            stall_exp = ((k % 7) < 4);
            drive(0, 1, 1, 16'h0300, 8'h00, 1, 0, da, 8'h00);
            n_cmp++; if (cpu_rdy !== ~stall_exp) begin
                n_err++; $display("FAIL %s_rdy[%0d]: got %b expected %b", tag, k, cpu_rdy, ~stall_exp);
            end
            n_cmp++; if (dma_gnt !== stall_exp) begin
                n_err++; $display("FAIL %s_gnt[%0d]: got %b expected %b", tag, k, dma_gnt, stall_exp);
            end
            n_cmp++; if (ram_addr !== (stall_exp ? da : 16'h0300)) begin
                n_err++; $display("FAIL %s_addr[%0d]: got %h expected %h", tag, k, ram_addr,
                                  stall_exp ? da : 16'h0300);
            end
            if (stall_exp) begin
                exp_q.push_back(shadow[da]);
                da = da + 16'd1;
            end
        end
        drive(0, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    endtask

    task automatic test_forced_offram();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 16'h0300, 8'h00, 1, 0, 16'h0800 + 16'(k), 8'h00);
            exp_q.push_back(shadow[16'h0800 + 16'(k)]);
        end
        drive(0, 1, 1, 16'h0300, 8'h00, 1, 0, 16'h0804, 8'h00);
        n_cmp++; if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0) begin
            n_err++; $display("FAIL fo_limit: got rdy=%b gnt=%b expected rdy=1 gnt=0", cpu_rdy, dma_gnt);
        end
        drive(0, 0, 1, 16'h0300, 8'h00, 1, 0, 16'h0804, 8'h00);
        n_cmp++; if (dma_gnt !== 1'b1 || cpu_rdy !== 1'b1) begin
            n_err++; $display("FAIL fo_offram_gnt: got rdy=%b gnt=%b expected rdy=1 gnt=1", cpu_rdy, dma_gnt);
        end
        n_cmp++; if (ram_addr !== 16'h0804) begin n_err++; $display("FAIL fo_offram_addr: got %h expected 0804", ram_addr); end
        exp_q.push_back(shadow[16'h0804]);
        // Still FORCED: a CPU read must beat DMA
        drive(0, 1, 1, 16'h0300, 8'h00, 1, 0, 16'h0805, 8'h00);
        n_cmp++; if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0) begin
            n_err++; $display("FAIL fo_still_forced: got rdy=%b gnt=%b expected rdy=1 gnt=0", cpu_rdy, dma_gnt);
        end
        drive(0, 1, 1, 16'h0300, 8'h00, 1, 0, 16'h0805, 8'h00);
        n_cmp++; if (cpu_rdy !== 1'b0 || dma_gnt !== 1'b1) begin
            n_err++; $display("FAIL fo_back_open: got rdy=%b gnt=%b expected rdy=0 gnt=1", cpu_rdy, dma_gnt);
        end
        exp_q.push_back(shadow[16'h0805]);
        drive(0, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    endtask

    task automatic test_read_integrity();
        drive(0, 0, 1, 16'h0000, 8'h00, 1, 1, 16'h0400, 8'hA5);
        n_cmp++; if (dma_gnt !== 1'b1 || ram_we !== 1'b1) begin
            n_err++; $display("FAIL ri_dma_write: got gnt=%b we=%b expected gnt=1 we=1", dma_gnt, ram_we);
        end
        shadow[16'h0400] = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 16'h0400, 8'h00, 1, 0, 16'h0600 + 16'(k), 8'h00);
            n_cmp++; if (cpu_rdy !== 1'b0) begin n_err++; $display("FAIL ri_stall[%0d]: got %b expected 0", k, cpu_rdy); end
            exp_q.push_back(shadow[16'h0600 + 16'(k)]);
        end
        drive(0, 1, 1, 16'h0400, 8'h00, 0, 0, 16'h0000, 8'h00);
        n_cmp++; if (cpu_rdy !== 1'b1 || ram_addr !== 16'h0400) begin
            n_err++; $display("FAIL ri_cpu_read: got rdy=%b addr=%h expected rdy=1 addr=0400", cpu_rdy, ram_addr);
        end
        drive(0, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        n_cmp++; if (ram_rdata !== 8'hA5) begin n_err++; $display("FAIL ri_cpu_di: got %h expected a5", ram_rdata); end
    endtask

    task automatic test_reset_midstall();
        drive(0, 1, 1, 16'h0300, 8'h00, 1, 0, 16'h0700, 8'h00);
        exp_q.push_back(shadow[16'h0700]);
        // This grant's rvalid would land in the reset cycle and must be dropped
        drive(0, 1, 1, 16'h0300, 8'h00, 1, 0, 16'h0701, 8'h00);
        drive(1, 1, 1, 16'h0300, 8'h00, 1, 0, 16'h0702, 8'h00);
        n_cmp++; if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0) begin
            n_err++; $display("FAIL rm_outputs: got rdy=%b gnt=%b expected rdy=1 gnt=0", cpu_rdy, dma_gnt);
        end
        n_cmp++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL rm_rvalid_drop: got %b expected 0", dma_rvalid); end
        drive(0, 1, 1, 16'h0300, 8'h00, 0, 0, 16'h0000, 8'h00);
        n_cmp++; if (cpu_rdy !== 1'b1 || dma_rvalid !== 1'b0) begin
            n_err++; $display("FAIL rm_after: got rdy=%b rvalid=%b expected rdy=1 rvalid=0", cpu_rdy, dma_rvalid);
        end
        test_stall_limit(16'h0900, 7, "rm");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) shadow[i] = pat(16'(i));
        reset = 1'b1; cpu_ab = '0; cpu_do = '0; cpu_we_n = 1'b1; cpu_ram_sel = 1'b0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        test_reset();
        test_no_conflict();
        test_cpu_write();
        test_stall_limit(16'h0500, 14, "sl");
        test_forced_offram();
        test_read_integrity();
        test_reset_midstall();
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        n_cmp++; if (exp_q.size() != 0) begin
            n_err++; $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
